code_lock_controller: RTL and testbench

//   Parametrised combination-lock sequencer; next generation of the lock state manager.

---
 rtl/code_lock_pkg.sv | 30 +++
 rtl/code_lock_controller_timer.sv | 34 +++
 rtl/code_lock_controller.sv | 137 +++++++++++++
 tb/tb_code_lock_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// code_lock_pkg
//   Shared definitions for the combination-lock sequencer and its display driver:
//   the state encoding (enum plus plain numeric constants) and a width helper
//   for the shared down-counter.
package code_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM1    = 3'd1,
    ST_ARM2    = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_OPEN    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  localparam logic [2:0] STATE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_ARM1    = 3'd1;
  localparam logic [2:0] STATE_ARM2    = 3'd2;
  localparam logic [2:0] STATE_VERIFY  = 3'd3;
  localparam logic [2:0] STATE_OPEN    = 3'd4;
  localparam logic [2:0] STATE_LOCKOUT = 3'd5;

  // Bits needed to hold (max(a,b) - 1); never less than one bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/code_lock_controller_timer.sv
// code_lock_timer
//   Loadable down-counter with a zero flag. Decrement saturates at zero.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_value this cycle (has priority over dec)
//   load_value  value to load
//   dec         decrement by one when nonzero
//   zero        count is zero
module code_lock_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/code_lock_controller.sv
// code_lock_controller
//   Combination-lock sequencer: IDLE->ARM1->ARM2->VERIFY on button_next strobes,
//   compares NUM_DIGITS shown digits against the password, counts consecutive
//   failures, holds LOCKOUT for LOCKOUT_CYCLES clocks after MAX_ATTEMPTS failures.
//   Optional macro CODE_LOCK_AUTO_RELOCK_EN: OPEN relocks to IDLE after
//   UNLOCK_CYCLES clocks without a press.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   button_next      one-cycle debounced strobe
//   digits_showing   displayed digits, digit k at [k*DIGIT_W +: DIGIT_W]
//   digits_password  password digits, same packing
//   state            current state (0 IDLE .. 5 LOCKOUT)
//   unlocked         state == OPEN
//   locked_out       state == LOCKOUT
//   attempts_left    MAX_ATTEMPTS minus current failure count
//   fail_pulse       one-cycle pulse per mismatched VERIFY press
module code_lock_controller
  import code_lock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned UNLOCK_CYCLES  = 500
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 button_next,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]        digits_showing,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]        digits_password,
  output logic [2:0]                           state,
  output logic                                 unlocked,
  output logic                                 locked_out,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    attempts_left,
  output logic                                 fail_pulse
);

  localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned TW = timer_width(LOCKOUT_CYCLES, UNLOCK_CYCLES);
  localparam logic [AW-1:0] MAX_A       = AW'(MAX_ATTEMPTS);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   fails_q, fails_d, fails_inc;
  logic            fail_pulse_q, fail_pulse_d;
  logic            timer_load, timer_dec, timer_zero;
  logic [TW-1:0]   timer_value;
  logic [NUM_DIGITS-1:0] digit_eq;
  logic            code_match;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_cmp
    assign digit_eq[k] = (digits_showing[k*DIGIT_W +: DIGIT_W] ==
                          digits_password[k*DIGIT_W +: DIGIT_W]);
  end
  assign code_match = &digit_eq;

  code_lock_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  assign fails_inc = fails_q + AW'(1);

  always_comb begin
    state_d      = state_q;
    fails_d      = fails_q;
    fail_pulse_d = 1'b0;
    timer_load   = 1'b0;
    timer_value  = '0;
    timer_dec    = 1'b0;
    case (state_q)
      ST_IDLE:   if (button_next) state_d = ST_ARM1;
      ST_ARM1:   if (button_next) state_d = ST_ARM2;
      ST_ARM2:   if (button_next) state_d = ST_VERIFY;
      ST_VERIFY: begin
        if (button_next) begin
          if (code_match) begin
            state_d     = ST_OPEN;
            fails_d     = '0;
            timer_load  = 1'b1;
            timer_value = UNLOCK_LOAD;
          end else begin
            fail_pulse_d = 1'b1;
            fails_d      = fails_inc;
            if (fails_inc == MAX_A) begin
              state_d     = ST_LOCKOUT;
              timer_load  = 1'b1;
              timer_value = LOCK_LOAD;
            end
          end
        end
      end
      ST_OPEN: begin
`ifdef CODE_LOCK_AUTO_RELOCK_EN
        timer_dec = 1'b1;
        if (timer_zero || button_next) state_d = ST_IDLE;
`else
        if (button_next) state_d = ST_IDLE;
`endif
      end
      ST_LOCKOUT: begin
        // Expiry takes precedence; presses are never looked at here.
        if (timer_zero) begin
          state_d = ST_IDLE;
          fails_d = '0;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fails_q      <= '0;
      fail_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fails_q      <= fails_d;
      fail_pulse_q <= fail_pulse_d;
    end
  end

  assign state         = state_q;
  assign unlocked      = (state_q == ST_OPEN);
  assign locked_out    = (state_q == ST_LOCKOUT);
  assign attempts_left = MAX_A - fails_q;
  assign fail_pulse    = fail_pulse_q;

endmodule

// File: tb/tb_code_lock_controller.sv
// tb_code_lock_controller
//   Directed bench for code_lock_controller (MAX_ATTEMPTS=3, LOCKOUT_CYCLES=8,
//   UNLOCK_CYCLES=4) plus a second instance with MAX_ATTEMPTS=1, LOCKOUT_CYCLES=2.
//   Follows CODE_LOCK_AUTO_RELOCK_EN for the relock expectations.
module tb_code_lock_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        button_next;
  logic [31:0] showing;
  logic [31:0] password;
  logic [2:0]  state;
  logic        unlocked, locked_out, fail_pulse;
  logic [1:0]  attempts_left;
  logic [2:0]  state1;
  logic        unlocked1, locked_out1, fail_pulse1;
  logic [0:0]  attempts_left1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  code_lock_controller #(
    .NUM_DIGITS(8), .DIGIT_W(4), .MAX_ATTEMPTS(3),
    .LOCKOUT_CYCLES(8), .UNLOCK_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button_next(button_next),
    .digits_showing(showing), .digits_password(password),
    .state(state), .unlocked(unlocked), .locked_out(locked_out),
    .attempts_left(attempts_left), .fail_pulse(fail_pulse)
  );

  code_lock_controller #(
    .NUM_DIGITS(8), .DIGIT_W(4), .MAX_ATTEMPTS(1),
    .LOCKOUT_CYCLES(2), .UNLOCK_CYCLES(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .button_next(button_next),
    .digits_showing(showing), .digits_password(password),
    .state(state1), .unlocked(unlocked1), .locked_out(locked_out1),
    .attempts_left(attempts_left1), .fail_pulse(fail_pulse1)
  );

  // One-cycle strobe; returns on the negedge after the sampling edge.
  task automatic press();
    @(negedge clk) button_next = 1'b1;
    @(negedge clk) button_next = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    button_next = 1'b0;
    password = 32'h1234_5678;
    showing  = 32'h1234_5678;
    repeat (2) @(negedge clk);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (attempts_left !== 2'd3) begin failures++; $display("FAIL reset_attempts got=%0d exp=3", attempts_left); end
    checks++; if ({unlocked, locked_out, fail_pulse} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {unlocked, locked_out, fail_pulse}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_hold got=%0d exp=0", state); end
  endtask

  task automatic test_unlock();
    showing = password;
    for (int i = 1; i <= 4; i++) begin
      press();
      checks++; if (state !== 3'(i)) begin failures++; $display("FAIL unlock_step%0d got=%0d exp=%0d", i, state, i); end
    end
    checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL unlock_flag got=%b exp=1", unlocked); end
    checks++; if (attempts_left !== 2'd3) begin failures++; $display("FAIL unlock_attempts got=%0d exp=3", attempts_left); end
    press();
    checks++; if (state !== 3'd0 || unlocked !== 1'b0) begin failures++; $display("FAIL open_to_idle got=%0d/%b exp=0/0", state, unlocked); end
  endtask

  task automatic test_fail_lockout();
    showing = password ^ 32'h000F_0000;  // digit5 differs
    repeat (3) press();
    for (int i = 1; i <= 3; i++) begin
      press();
      checks++; if (fail_pulse !== 1'b1) begin failures++; $display("FAIL fail_pulse%0d got=%b exp=1", i, fail_pulse); end
      checks++; if (attempts_left !== 2'(3 - i)) begin failures++; $display("FAIL fail_attempts%0d got=%0d exp=%0d", i, attempts_left, 3 - i); end
      checks++; if (state !== ((i == 3) ? 3'd5 : 3'd3)) begin failures++; $display("FAIL fail_state%0d got=%0d exp=%0d", i, state, (i == 3) ? 5 : 3); end
      if (i == 1) begin
        @(negedge clk);
        checks++; if (fail_pulse !== 1'b0) begin failures++; $display("FAIL fail_pulse_width got=%b exp=0", fail_pulse); end
      end
    end
    checks++; if (locked_out !== 1'b1) begin failures++; $display("FAIL locked_out got=%b exp=1", locked_out); end
  endtask

  task automatic test_lockout_timer();
    button_next = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (state !== ((i < 8) ? 3'd5 : 3'd0)) begin failures++; $display("FAIL lockout_cycle%0d got=%0d exp=%0d", i, state, (i < 8) ? 5 : 0); end
    end
    button_next = 1'b0;
    checks++; if (attempts_left !== 2'd3) begin failures++; $display("FAIL lockout_exit_attempts got=%0d exp=3", attempts_left); end
    @(negedge clk);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL lockout_press_dropped got=%0d exp=0", state); end
  endtask

  task automatic test_partial_fail();
    showing = password ^ 32'h0000_0001;
    repeat (3) press();
    repeat (2) press();
    checks++; if (attempts_left !== 2'd1) begin failures++; $display("FAIL partial_attempts got=%0d exp=1", attempts_left); end
    showing = password;
    press();
    checks++; if (state !== 3'd4 || attempts_left !== 2'd3) begin failures++; $display("FAIL partial_open got=%0d/%0d exp=4/3", state, attempts_left); end
    press();
    showing = password ^ 32'hF000_0000;
    repeat (3) press();
    repeat (2) press();
    checks++; if (state !== 3'd3 || attempts_left !== 2'd1) begin failures++; $display("FAIL round2_two got=%0d/%0d exp=3/1", state, attempts_left); end
    press();
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL round2_lock got=%0d exp=5", state); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || attempts_left !== 2'd3 || locked_out !== 1'b0) begin failures++; $display("FAIL rst_lockout got=%0d/%0d/%b exp=0/3/0", state, attempts_left, locked_out); end
    @(negedge clk) rst_n = 1'b1;
    press();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL rst_lockout_press got=%0d exp=1", state); end
    press();
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_arm2 got=%0d exp=0", state); end
    @(negedge clk) rst_n = 1'b1;
    press();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL rst_arm2_press got=%0d exp=1", state); end
  endtask

  task automatic test_auto_relock();
    do_reset();
    showing = password;
    repeat (4) press();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL relock_entry got=%0d exp=4", state); end
`ifdef CODE_LOCK_AUTO_RELOCK_EN
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (state !== ((i < 4) ? 3'd4 : 3'd0)) begin failures++; $display("FAIL relock_cycle%0d got=%0d exp=%0d", i, state, (i < 4) ? 4 : 0); end
    end
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++; if (state !== 3'd4) begin failures++; $display("FAIL hold_open%0d got=%0d exp=4", i, state); end
    end
`endif
  endtask

  task automatic test_max_one();
    do_reset();
    showing = password ^ 32'h0000_0F00;
    repeat (3) press();
    press();
    checks++; if (state !== 3'd3 || attempts_left !== 2'd2) begin failures++; $display("FAIL max3_first got=%0d/%0d exp=3/2", state, attempts_left); end
    checks++; if (state1 !== 3'd5 || locked_out1 !== 1'b1 || fail_pulse1 !== 1'b1) begin failures++; $display("FAIL max1_lock got=%0d/%b/%b exp=5/1/1", state1, locked_out1, fail_pulse1); end
    checks++; if (attempts_left1 !== 1'd0) begin failures++; $display("FAIL max1_attempts got=%0d exp=0", attempts_left1); end
    @(negedge clk);
    checks++; if (state1 !== 3'd5) begin failures++; $display("FAIL max1_hold got=%0d exp=5", state1); end
    @(negedge clk);
    checks++; if (state1 !== 3'd0 || attempts_left1 !== 1'd1) begin failures++; $display("FAIL max1_exit got=%0d/%0d exp=0/1", state1, attempts_left1); end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_fail_lockout();
    test_lockout_timer();
    test_partial_fail();
    test_reset_midop();
    test_auto_relock();
    test_max_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
